in3_xnor_gate: RTL and testbench



---
 rtl/in3_xnor_gate.sv | 60 ++++++
 tb/tb_in3_xnor_gate.sv | 132 +++++++++++++
 2 files changed

// File: rtl/in3_xnor_gate.sv
// Three-input XNOR (even parity) with a registered copy and, when
// IN3_XNOR_STATS_EN is defined, a change strobe and a saturating high-cycle counter.
module in3_xnor_gate #(
    parameter int CNT_W = 8
) (
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             out,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output logic             out_q,
    output logic             chg,
    output logic [CNT_W-1:0] hi_cnt
);

    logic w_xnor;
    logic r_out_q;

    // Plain expression so X/Z on any input reaches out unmasked.
    assign w_xnor = ~(a ^ b ^ c);
    assign out    = w_xnor;
    assign out_q  = r_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q <= 1'b0;
        end else begin
            r_out_q <= w_xnor;
        end
    end

`ifdef IN3_XNOR_STATS_EN
    logic [CNT_W-1:0] r_hi_cnt;
    logic             w_cnt_sat;

    assign w_cnt_sat = (r_hi_cnt == {CNT_W{1'b1}});
    assign chg       = w_xnor ^ r_out_q;
    assign hi_cnt    = r_hi_cnt;

    // clr outranks counting, including when saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_cnt <= '0;
        end else if (clr) begin
            r_hi_cnt <= '0;
        end else if (w_xnor && !w_cnt_sat) begin
            r_hi_cnt <= r_hi_cnt + 1'b1;
        end
    end
`else
    logic w_unused_clr;

    assign w_unused_clr = clr;
    assign chg          = 1'b0;
    assign hi_cnt       = '0;
`endif

endmodule

// File: tb/tb_in3_xnor_gate.sv
// Directed bench for in3_xnor_gate; expectations follow IN3_XNOR_STATS_EN.
module tb_in3_xnor_gate;

`ifdef IN3_XNOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       a, b, c, clk, rst_n, clr;
    logic       out, out_q, chg;
    logic [1:0] hi_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    in3_xnor_gate #(.CNT_W(2)) dut (
        .a(a), .b(b), .c(c), .out(out),
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .out_q(out_q), .chg(chg), .hi_cnt(hi_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_abc(input logic [2:0] v);
        {a, b, c} = v;
        #1;
    endtask

    // Checks the full output set; stats outputs expected 0 when the feature is off.
    task automatic check_all(input string tag, input logic e_out, input logic e_q,
                             input logic e_chg, input logic [1:0] e_cnt);
        check({tag, ".out"},    {7'b0, out},    {7'b0, e_out});
        check({tag, ".out_q"},  {7'b0, out_q},  {7'b0, e_q});
        check({tag, ".chg"},    {7'b0, chg},    {7'b0, e_chg & STATS});
        check({tag, ".hi_cnt"}, {6'b0, hi_cnt}, {6'b0, (STATS ? e_cnt : 2'd0)});
    endtask

    logic [7:0] tt;
    logic [1:0] sat_seq [5];

    initial begin
        tt = 8'b0110_1001;
        sat_seq[0] = 2'd1; sat_seq[1] = 2'd2; sat_seq[2] = 2'd3;
        sat_seq[3] = 2'd3; sat_seq[4] = 2'd3;

        rst_n = 1'b0;
        clr   = 1'b0;
        set_abc(3'b000);
        check_all("reset", 1'b1, 1'b0, 1'b1, 2'd0);

        // Truth table while held in reset: out independent of clock/reset.
        for (int i = 0; i < 8; i++) begin
            set_abc(i[2:0]);
            #9;
            check($sformatf("tt%0d.out", i), {7'b0, out}, {7'b0, tt[i]});
            check($sformatf("tt%0d.chg", i), {7'b0, chg}, {7'b0, tt[i] & STATS});
        end
        check("tt.out_q", {7'b0, out_q}, 8'h00);

        @(negedge clk);
        set_abc(3'b011);
        rst_n = 1'b1;
        tick();
        check_all("reg_hold", 1'b1, 1'b1, 1'b0, 2'd1);
        set_abc(3'b001);
        check_all("reg_change", 1'b0, 1'b1, 1'b1, 2'd1);
        tick();
        check_all("reg_settled", 1'b0, 1'b0, 1'b0, 2'd1);

        // Saturation with CNT_W=2.
        set_abc(3'b000);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_all("pre_clr", 1'b1, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all($sformatf("sat%0d", i), 1'b1, 1'b1, 1'b0, sat_seq[i]);
        end

        // Clear while saturated and out=1 wins, then counting resumes.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_all("clr_prio", 1'b1, 1'b1, 1'b0, 2'd0);
        tick();
        check_all("clr_resume", 1'b1, 1'b1, 1'b0, 2'd1);

        // A glitch between edges is not counted: only the edge value matters.
        set_abc(3'b001);
        check_all("glitch", 1'b0, 1'b1, 1'b1, 2'd1);
        set_abc(3'b000);
        tick();
        check_all("post_glitch", 1'b1, 1'b1, 1'b0, 2'd2);
        tick();
        check_all("resat", 1'b1, 1'b1, 1'b0, 2'd3);

        // Asynchronous reset between edges.
        #2;
        set_abc(3'b110);
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b1, 1'b0, 1'b1, 2'd0);
        set_abc(3'b111);
        check_all("rst_track", 1'b0, 1'b0, 1'b0, 2'd0);

        @(negedge clk);
        set_abc(3'b000);
        rst_n = 1'b1;
        tick();
        check_all("post_rst", 1'b1, 1'b1, 1'b0, 2'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
